// File: rtl/pipe_hold_ctrl.sv
// Pipeline hazard/flow controller: arbitrates jump redirects, multi-cycle
// divide, load-use hazards and fetch-bus wait into hold/stall controls.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   jump_req_i/addr_i : EX taken branch/jump pulse and its target
//   div_start_i       : EX launched a multi-cycle divide
//   div_done_i        : divider result valid pulse
//   load_use_i        : ID load-use hazard (level)
//   bus_wait_i        : instruction bus not ready this cycle
//   jump_en_o/addr_o  : PC redirect and target (target is 0 when not redirecting)
//   stall_pc_o        : freeze PC
//   stall_if_id_o     : freeze IF/ID
//   flush_if_id_o     : bubble into IF/ID
//   flush_id_ex_o     : bubble into ID/EX
//   err_o             : sticky divide-timeout error
//   stall_cnt_o       : saturating count of cycles with stall_pc_o=1
module pipe_hold_ctrl #(
    parameter int AW          = 32,
    parameter int FLUSH_CYC   = 2,
    parameter int DIV_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             jump_req_i,
    input  logic [AW-1:0]    jump_addr_i,
    input  logic             div_start_i,
    input  logic             div_done_i,
    input  logic             load_use_i,
    input  logic             bus_wait_i,
    output logic             jump_en_o,
    output logic [AW-1:0]    jump_addr_o,
    output logic             stall_pc_o,
    output logic             stall_if_id_o,
    output logic             flush_if_id_o,
    output logic             flush_id_ex_o,
    output logic             err_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam int DIV_W = $clog2(DIV_TIMEOUT + 1);

    localparam logic [3:0]       RELOAD   = 4'(FLUSH_CYC - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_TIMEOUT);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLUSH    = 2'd1,
        DIV_WAIT = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [3:0]       flush_cnt;
    logic [3:0]       flush_cnt_nxt;
    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_cnt_nxt;
    logic             err_set;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            flush_cnt <= 4'd0;
            div_cnt   <= '0;
        end else begin
            state     <= state_nxt;
            flush_cnt <= flush_cnt_nxt;
            div_cnt   <= div_cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_o <= 1'b0;
        end else if (err_set) begin
            err_o <= 1'b1;
        end
    end

    // Saturate rather than wrap so a long run never reads back as small.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_o <= '0;
        end else if (stall_pc_o && (stall_cnt_o != '1)) begin
            stall_cnt_o <= stall_cnt_o + CNT_W'(1);
        end
    end

    always_comb begin
        state_nxt     = state;
        flush_cnt_nxt = flush_cnt;
        div_cnt_nxt   = div_cnt;
        err_set       = 1'b0;
        jump_en_o     = 1'b0;
        jump_addr_o   = '0;
        stall_pc_o    = 1'b0;
        stall_if_id_o = 1'b0;
        flush_if_id_o = 1'b0;
        flush_id_ex_o = 1'b0;

        if (rst) begin
            // Both stage registers hold bubbles while in reset.
            flush_if_id_o = 1'b1;
            flush_id_ex_o = 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (jump_req_i) begin
                        jump_en_o     = 1'b1;
                        jump_addr_o   = jump_addr_i;
                        flush_if_id_o = 1'b1;
                        flush_id_ex_o = 1'b1;
                        if (FLUSH_CYC > 1) begin
                            state_nxt     = FLUSH;
                            flush_cnt_nxt = RELOAD;
                        end
                    end else if (div_start_i) begin
                        stall_pc_o    = 1'b1;
                        stall_if_id_o = 1'b1;
                        flush_id_ex_o = 1'b1;
                        state_nxt     = DIV_WAIT;
                        div_cnt_nxt   = DIV_W'(1);
                    end else if (load_use_i) begin
                        stall_pc_o    = 1'b1;
                        stall_if_id_o = 1'b1;
                        flush_id_ex_o = 1'b1;
                    end else if (bus_wait_i) begin
                        stall_pc_o    = 1'b1;
                        flush_if_id_o = 1'b1;
                    end
                end

                FLUSH: begin
                    flush_if_id_o = 1'b1;
                    stall_pc_o    = bus_wait_i;
                    if (jump_req_i) begin
                        // A newer redirect restarts the flush window.
                        jump_en_o     = 1'b1;
                        jump_addr_o   = jump_addr_i;
                        flush_id_ex_o = 1'b1;
                        flush_cnt_nxt = RELOAD;
                    end else if (flush_cnt <= 4'd1) begin
                        state_nxt = IDLE;
                    end else begin
                        flush_cnt_nxt = flush_cnt - 4'd1;
                    end
                end

                DIV_WAIT: begin
                    if (!div_done_i) begin
                        stall_pc_o    = 1'b1;
                        stall_if_id_o = 1'b1;
                        flush_id_ex_o = 1'b1;
                        if (div_cnt >= DIV_LAST) begin
                            // Divider never answered: abort and flag it.
                            err_set   = 1'b1;
                            state_nxt = IDLE;
                        end else begin
                            div_cnt_nxt = div_cnt + DIV_W'(1);
                        end
                    end else begin
                        state_nxt = IDLE;
                    end
                end

                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_hold_ctrl.sv
// Directed bench for pipe_hold_ctrl: reset, jump flush, back-to-back jumps,
// divide stall/timeout, priority arbitration and counter saturation.
module tb_pipe_hold_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        jump_req;
    logic [31:0] jump_addr;
    logic        div_start;
    logic        div_done;
    logic        load_use;
    logic        bus_wait;

    logic        jump_en;
    logic [31:0] jump_addr_q;
    logic        stall_pc;
    logic        stall_if_id;
    logic        flush_if_id;
    logic        flush_id_ex;
    logic        err;
    logic [31:0] stall_cnt;

    logic        s_jump_en;
    logic [31:0] s_jump_addr_q;
    logic        s_stall_pc;
    logic        s_stall_if_id;
    logic        s_flush_if_id;
    logic        s_flush_id_ex;
    logic        s_err;
    logic [3:0]  s_stall_cnt;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    pipe_hold_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .jump_req_i   (jump_req),
        .jump_addr_i  (jump_addr),
        .div_start_i  (div_start),
        .div_done_i   (div_done),
        .load_use_i   (load_use),
        .bus_wait_i   (bus_wait),
        .jump_en_o    (jump_en),
        .jump_addr_o  (jump_addr_q),
        .stall_pc_o   (stall_pc),
        .stall_if_id_o(stall_if_id),
        .flush_if_id_o(flush_if_id),
        .flush_id_ex_o(flush_id_ex),
        .err_o        (err),
        .stall_cnt_o  (stall_cnt)
    );

    pipe_hold_ctrl #(.CNT_W(4)) dut_small (
        .clk          (clk),
        .rst          (rst),
        .jump_req_i   (jump_req),
        .jump_addr_i  (jump_addr),
        .div_start_i  (div_start),
        .div_done_i   (div_done),
        .load_use_i   (load_use),
        .bus_wait_i   (bus_wait),
        .jump_en_o    (s_jump_en),
        .jump_addr_o  (s_jump_addr_q),
        .stall_pc_o   (s_stall_pc),
        .stall_if_id_o(s_stall_if_id),
        .flush_if_id_o(s_flush_if_id),
        .flush_id_ex_o(s_flush_id_ex),
        .err_o        (s_err),
        .stall_cnt_o  (s_stall_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        jump_req  = 1'b0;
        jump_addr = 32'h0;
        div_start = 1'b0;
        div_done  = 1'b0;
        load_use  = 1'b0;
        bus_wait  = 1'b0;
    endtask

    task automatic reset_pulse();
        clear_in();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_in();
        rst = 1'b1;
        bus_wait = 1'b1;
        tick();
        tick();
        @(negedge clk);
        vecs++; if (flush_if_id !== 1'b1) begin errs++; $display("FAIL rst_fif: got %b want 1", flush_if_id); end
        vecs++; if (flush_id_ex !== 1'b1) begin errs++; $display("FAIL rst_fie: got %b want 1", flush_id_ex); end
        vecs++; if (stall_pc !== 1'b0) begin errs++; $display("FAIL rst_stall_pc: got %b want 0", stall_pc); end
        vecs++; if (jump_en !== 1'b0) begin errs++; $display("FAIL rst_jump_en: got %b want 0", jump_en); end
        vecs++; if (stall_cnt !== 32'd0) begin errs++; $display("FAIL rst_cnt: got %0d want 0", stall_cnt); end
        vecs++; if (err !== 1'b0) begin errs++; $display("FAIL rst_err: got %b want 0", err); end
        rst = 1'b0;
        bus_wait = 1'b0;
        tick();
    endtask

    task automatic test_jump();
        jump_req  = 1'b1;
        jump_addr = 32'h0000_0100;
        @(negedge clk);
        vecs++; if (jump_en !== 1'b1) begin errs++; $display("FAIL jmp_en: got %b want 1", jump_en); end
        vecs++; if (jump_addr_q !== 32'h100) begin errs++; $display("FAIL jmp_addr: got %h want 100", jump_addr_q); end
        vecs++; if ({flush_if_id, flush_id_ex} !== 2'b11) begin errs++; $display("FAIL jmp_flush: got %b want 11", {flush_if_id, flush_id_ex}); end
        vecs++; if (stall_pc !== 1'b0) begin errs++; $display("FAIL jmp_stall: got %b want 0", stall_pc); end
        tick();
        jump_req  = 1'b0;
        jump_addr = 32'hdead_beef;
        @(negedge clk);
        vecs++; if (jump_en !== 1'b0) begin errs++; $display("FAIL jmp1_en: got %b want 0", jump_en); end
        vecs++; if (jump_addr_q !== 32'h0) begin errs++; $display("FAIL jmp1_addr: got %h want 0", jump_addr_q); end
        vecs++; if ({flush_if_id, flush_id_ex} !== 2'b10) begin errs++; $display("FAIL jmp1_flush: got %b want 10", {flush_if_id, flush_id_ex}); end
        tick();
        clear_in();
        @(negedge clk);
        vecs++; if ({flush_if_id, flush_id_ex, stall_pc, stall_if_id, jump_en} !== 5'b0) begin errs++; $display("FAIL jmp2_idle: got %b want 00000", {flush_if_id, flush_id_ex, stall_pc, stall_if_id, jump_en}); end
        tick();
    endtask

    task automatic test_back_to_back();
        jump_req  = 1'b1;
        jump_addr = 32'h0000_0100;
        tick();
        jump_addr = 32'h0000_0200;
        @(negedge clk);
        vecs++; if (jump_en !== 1'b1) begin errs++; $display("FAIL b2b_en: got %b want 1", jump_en); end
        vecs++; if (jump_addr_q !== 32'h200) begin errs++; $display("FAIL b2b_addr: got %h want 200", jump_addr_q); end
        vecs++; if ({flush_if_id, flush_id_ex} !== 2'b11) begin errs++; $display("FAIL b2b_flush: got %b want 11", {flush_if_id, flush_id_ex}); end
        tick();
        jump_req = 1'b0;
        load_use = 1'b1;
        bus_wait = 1'b1;
        @(negedge clk);
        vecs++; if (flush_if_id !== 1'b1) begin errs++; $display("FAIL b2b_t2_fif: got %b want 1", flush_if_id); end
        vecs++; if ({stall_if_id, flush_id_ex} !== 2'b00) begin errs++; $display("FAIL b2b_t2_lu_ignored: got %b want 00", {stall_if_id, flush_id_ex}); end
        vecs++; if (stall_pc !== 1'b1) begin errs++; $display("FAIL b2b_t2_buswait: got %b want 1", stall_pc); end
        tick();
        clear_in();
        @(negedge clk);
        vecs++; if ({flush_if_id, stall_pc} !== 2'b00) begin errs++; $display("FAIL b2b_t3_idle: got %b want 00", {flush_if_id, stall_pc}); end
        tick();
    endtask

    task automatic test_div();
        reset_pulse();
        div_start = 1'b1;
        @(negedge clk);
        vecs++; if ({stall_pc, stall_if_id, flush_id_ex, flush_if_id} !== 4'b1110) begin errs++; $display("FAIL div_t0: got %b want 1110", {stall_pc, stall_if_id, flush_id_ex, flush_if_id}); end
        tick();
        div_start = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            jump_req = (i == 2);
            jump_addr = 32'h0000_0400;
            @(negedge clk);
            vecs++; if ({stall_pc, stall_if_id, flush_id_ex, jump_en} !== 4'b1110) begin errs++; $display("FAIL div_t%0d: got %b want 1110", i, {stall_pc, stall_if_id, flush_id_ex, jump_en}); end
            tick();
        end
        clear_in();
        div_done = 1'b1;
        @(negedge clk);
        vecs++; if ({stall_pc, stall_if_id, flush_id_ex, flush_if_id} !== 4'b0000) begin errs++; $display("FAIL div_done: got %b want 0000", {stall_pc, stall_if_id, flush_id_ex, flush_if_id}); end
        tick();
        div_done = 1'b0;
        @(negedge clk);
        vecs++; if (stall_cnt !== 32'd5) begin errs++; $display("FAIL div_cnt: got %0d want 5", stall_cnt); end
        vecs++; if (stall_pc !== 1'b0) begin errs++; $display("FAIL div_idle: got %b want 0", stall_pc); end
        tick();
    endtask

    task automatic test_timeout();
        reset_pulse();
        div_start = 1'b1;
        tick();
        div_start = 1'b0;
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            if (k == 1 || k == 64) begin
                vecs++; if ({stall_pc, err} !== 2'b10) begin errs++; $display("FAIL tmo_wait%0d: got %b want 10", k, {stall_pc, err}); end
            end
            tick();
        end
        @(negedge clk);
        vecs++; if (err !== 1'b1) begin errs++; $display("FAIL tmo_err: got %b want 1", err); end
        vecs++; if (stall_pc !== 1'b0) begin errs++; $display("FAIL tmo_release: got %b want 0", stall_pc); end
        vecs++; if (stall_cnt !== 32'd65) begin errs++; $display("FAIL tmo_cnt: got %0d want 65", stall_cnt); end
        tick();
        tick();
        tick();
        @(negedge clk);
        vecs++; if (err !== 1'b1) begin errs++; $display("FAIL tmo_sticky: got %b want 1", err); end
        reset_pulse();
        @(negedge clk);
        vecs++; if (err !== 1'b0) begin errs++; $display("FAIL tmo_clear: got %b want 0", err); end
        tick();
    endtask

    task automatic test_priority();
        jump_req  = 1'b1;
        jump_addr = 32'h0000_0300;
        load_use  = 1'b1;
        bus_wait  = 1'b1;
        @(negedge clk);
        vecs++; if ({jump_en, stall_pc, stall_if_id} !== 3'b100) begin errs++; $display("FAIL pri_jump: got %b want 100", {jump_en, stall_pc, stall_if_id}); end
        vecs++; if (jump_addr_q !== 32'h300) begin errs++; $display("FAIL pri_addr: got %h want 300", jump_addr_q); end
        tick();
        clear_in();
        tick();
        load_use = 1'b1;
        bus_wait = 1'b1;
        @(negedge clk);
        vecs++; if ({stall_pc, stall_if_id, flush_id_ex, flush_if_id} !== 4'b1110) begin errs++; $display("FAIL pri_lu: got %b want 1110", {stall_pc, stall_if_id, flush_id_ex, flush_if_id}); end
        tick();
        load_use = 1'b0;
        @(negedge clk);
        vecs++; if ({stall_pc, stall_if_id, flush_id_ex, flush_if_id} !== 4'b1001) begin errs++; $display("FAIL pri_bw: got %b want 1001", {stall_pc, stall_if_id, flush_id_ex, flush_if_id}); end
        tick();
        clear_in();
        tick();
    endtask

    task automatic test_saturate();
        reset_pulse();
        load_use = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
        end
        load_use = 1'b0;
        @(negedge clk);
        vecs++; if (s_stall_cnt !== 4'd15) begin errs++; $display("FAIL sat_small: got %0d want 15", s_stall_cnt); end
        vecs++; if (stall_cnt !== 32'd20) begin errs++; $display("FAIL sat_wide: got %0d want 20", stall_cnt); end
        div_start = 1'b1;
        tick();
        div_start = 1'b0;
        tick();
        rst = 1'b1;
        @(negedge clk);
        vecs++; if ({stall_pc, flush_if_id, flush_id_ex} !== 3'b011) begin errs++; $display("FAIL abort_in_rst: got %b want 011", {stall_pc, flush_if_id, flush_id_ex}); end
        tick();
        rst = 1'b0;
        @(negedge clk);
        vecs++; if ({stall_pc, stall_if_id, flush_id_ex} !== 3'b000) begin errs++; $display("FAIL abort_idle: got %b want 000", {stall_pc, stall_if_id, flush_id_ex}); end
        vecs++; if (stall_cnt !== 32'd0) begin errs++; $display("FAIL abort_cnt: got %0d want 0", stall_cnt); end
        tick();
    endtask

    initial begin
        rst = 1'b1;
        clear_in();
        test_reset();
        test_jump();
        test_back_to_back();
        test_div();
        test_timeout();
        test_priority();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/pipe_hold_ctrl.md
Name: pipe_hold_ctrl

Overview:
Pipeline hazard/flow controller; the producer of the hold (flush) and stall controls consumed by the pipeline registers.
- Flush outputs drive the `hold_flag_i` of the set-on-hold stage registers. Asserted (`HoldEnable`) means the register loads its bubble value.
- Stall outputs freeze the PC and IF/ID register.
- Arbitrates jump redirects from EX, multi-cycle divide, load-use hazards and fetch-bus wait.
- Sits between IF/ID/EX and the PC/stage registers.

Parameters:
- AW, 32, jump address width.
- FLUSH_CYC, 2, total IF/ID flush cycles per taken jump, including the jump cycle; legal range 1..15.
- DIV_TIMEOUT, 64, maximum DIV_WAIT cycles before the error abort; must be at least 2.
- CNT_W, 32, stall performance counter width.

Ports:
- clk, in, 1: clock.
- rst, in, 1: synchronous reset, active-high.
- jump_req_i, in, 1: EX taken branch/jump, single-cycle pulse.
- jump_addr_i, in, AW: jump target.
- div_start_i, in, 1: EX launched a multi-cycle divide.
- div_done_i, in, 1: divider result valid (pulse).
- load_use_i, in, 1: ID load-use hazard, level.
- bus_wait_i, in, 1: instruction bus not ready this cycle.
- jump_en_o, out, 1: PC redirect.
- jump_addr_o, out, AW: PC redirect target.
- stall_pc_o, out, 1: freeze PC.
- stall_if_id_o, out, 1: freeze IF/ID.
- flush_if_id_o, out, 1: hold flag to IF/ID (bubble).
- flush_id_ex_o, out, 1: hold flag to ID/EX (bubble).
- err_o, out, 1: sticky divide-timeout error.
- stall_cnt_o, out, CNT_W: cycles with stall_pc_o=1.

Behaviour:
- States: IDLE, FLUSH, DIV_WAIT. Registered state, flush down-counter (4 b), divide cycle counter, err flag, stall counter. All control outputs are combinational from state + inputs (same-cycle effect).

Reset, while rst=1:
- State goes to IDLE; counters are cleared; err_o=0; stall_cnt_o=0.
- Outputs: flush_if_id_o=1, flush_id_ex_o=1, stall_*=0, jump_en_o=0, jump_addr_o=0.
- Reset mid-FLUSH or mid-DIV_WAIT aborts immediately.

IDLE, priority jump > div_start > load_use > bus_wait:
- jump_req_i:
  - jump_en_o=1 and jump_addr_o=jump_addr_i in the same cycle.
  - flush_if_id_o=1 and flush_id_ex_o=1.
  - If FLUSH_CYC>1: go to FLUSH, counter=FLUSH_CYC-1.
- div_start_i:
  - stall_pc_o=1, stall_if_id_o=1, flush_id_ex_o=1.
  - Go to DIV_WAIT with divide counter=1.
- load_use_i: stall_pc_o=1, stall_if_id_o=1, flush_id_ex_o=1. Stays IDLE.
- bus_wait_i: stall_pc_o=1, flush_if_id_o=1. Stays IDLE.
- Otherwise all controls are 0.
- jump_addr_o=0 whenever jump_en_o=0.

FLUSH:
- flush_if_id_o=1 every cycle. Counter decrements; at counter==1 return to IDLE next edge.
- jump_req_i in FLUSH: redirect as in IDLE, flush both, counter reloads to FLUSH_CYC-1.
- div_start_i and load_use_i are ignored (EX/ID hold bubbles).
- bus_wait_i in FLUSH adds stall_pc_o=1.

DIV_WAIT:
- stall_pc_o=1, stall_if_id_o=1, flush_id_ex_o=1 each cycle. Divide counter increments.
- div_done_i=1: all stalls/flushes are 0 that cycle; return to IDLE next edge.
- Counter reaching DIV_TIMEOUT without done: err_o set (sticky until rst); return to IDLE next edge; stalls still 1 that cycle.
- jump_req_i, load_use_i, bus_wait_i are ignored. div_done_i outside DIV_WAIT is ignored.
- div_start_i together with div_done_i in DIV_WAIT: done wins, return to IDLE.

Stall counter:
- Increments on each non-reset cycle with stall_pc_o=1.
- Saturates at all-ones; no wrap.

Test Plan:
- rst=1 for 2 cycles, then jump_req_i=1 with jump_addr_i=0x0000_0100 for 1 cycle -> during reset flush_if_id_o=flush_id_ex_o=1 and stall_cnt_o=0. Jump cycle: jump_en_o=1, jump_addr_o=0x100, both flushes=1. Next cycle: flush_if_id_o=1 only. Cycle after: all 0.
- Jump at T, second jump 0x200 at T+1 (FLUSH) -> redirect to 0x200 at T+1; flush_if_id_o=1 through T+2; IDLE at T+3.
- div_start_i at T, div_done_i at T+5 -> stall_pc_o/stall_if_id_o/flush_id_ex_o=1 for T..T+4 and 0 at T+5; stall_cnt_o=5 afterwards.
- div_start_i with no done, DIV_TIMEOUT=64 -> err_o=1 from the cycle after the 64th DIV_WAIT cycle and stays 1; stalls release; only rst clears err_o.
- Same cycle jump_req_i=1, load_use_i=1, bus_wait_i=1 in IDLE -> jump behaviour only, stall_pc_o=0. Then load_use_i=1 with bus_wait_i=1 -> stall_pc_o=stall_if_id_o=flush_id_ex_o=1, flush_if_id_o=0.
- CNT_W=4: hold load_use_i=1 for 20 cycles -> stall_cnt_o saturates at 15. Assert rst mid-DIV_WAIT -> next cycle IDLE, counter 0, no stall.
